// File: rtl/seg7_bcd_decoder.sv
// rtl/seg7_bcd_decoder.sv - seven-segment bus to BCD decoder with stability filter and valid/ready output
// Optional feature macro: SEG7_DEC_DROP_ERR_EN (bus values holding an invalid digit are dropped, err_out tied 0)
module seg7_bcd_decoder #(
    parameter int NUM_DISP      = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DISP*7-1:0] seg_in,
    output logic [NUM_DISP*4-1:0] bcd_out,
    output logic [NUM_DISP-1:0]   dash_out,
    output logic [NUM_DISP-1:0]   err_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);
    localparam logic [6:0]            DASH     = 7'b1111110;
    localparam logic [7:0]            STABLE   = 8'(STABLE_CYCLES);
    localparam logic [NUM_DISP*7-1:0] BUS_DASH = {NUM_DISP{DASH}};

    typedef enum logic {IDLE, PEND} state_t;
    state_t state, state_nxt;

    logic [NUM_DISP*7-1:0] samp_q;
    logic [NUM_DISP*7-1:0] last_acc;
    logic [7:0]            cnt;
    logic [7:0]            cnt_nxt;
    logic                  changed;
    logic                  hit_q;
    logic                  qual;
    logic                  capture;
    logic [NUM_DISP*4-1:0] dec_bcd;
    logic [NUM_DISP-1:0]   dec_dash;
    logic [NUM_DISP-1:0]   dec_err;

    // Returns {err, dash, bcd} for one active-low a..g pattern.
    function automatic logic [5:0] decode_digit(input logic [6:0] pat);
        case (pat)
            7'b0000001: return {2'b00, 4'd0};
            7'b1001111: return {2'b00, 4'd1};
            7'b0010010: return {2'b00, 4'd2};
            7'b0000110: return {2'b00, 4'd3};
            7'b1001100: return {2'b00, 4'd4};
            7'b0100100: return {2'b00, 4'd5};
            7'b0100000: return {2'b00, 4'd6};
            7'b0001111: return {2'b00, 4'd7};
            7'b0000000: return {2'b00, 4'd8};
            7'b0000100: return {2'b00, 4'd9};
            DASH:       return {2'b01, 4'hF};
            default:    return {2'b10, 4'hE};
        endcase
    endfunction

    // Decode every digit of the sampled bus.
    always_comb begin
        dec_bcd  = '0;
        dec_dash = '0;
        dec_err  = '0;
        for (int i = 0; i < NUM_DISP; i++) begin
            {dec_err[i], dec_dash[i], dec_bcd[4*i +: 4]} = decode_digit(samp_q[7*i +: 7]);
        end
    end

    assign changed = (seg_in != samp_q);

    // Run-length counter of identical samples, saturating at the stability threshold.
    always_comb begin
        if (changed) begin
            cnt_nxt = 8'd1;
        end else if (cnt != STABLE) begin
            cnt_nxt = cnt + 8'd1;
        end else begin
            cnt_nxt = cnt;
        end
    end

    // Sample register, counter, and a flag marking the first cycle the counter sits at threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= BUS_DASH;
            cnt    <= STABLE;
            hit_q  <= 1'b0;
        end else begin
            samp_q <= seg_in;
            cnt    <= cnt_nxt;
            hit_q  <= (cnt_nxt == STABLE) && ((cnt != STABLE) || changed);
        end
    end

`ifdef SEG7_DEC_DROP_ERR_EN
    assign qual = (cnt == STABLE) && (samp_q != last_acc) && !(|dec_err);
`else
    assign qual = (cnt == STABLE) && (samp_q != last_acc);
`endif
    assign capture = qual && ((state == IDLE) || out_ready);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a capture always leaves a value pending; a handshake without capture empties it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture) state_nxt = PEND;
            PEND: if (!capture && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        out_valid = (state == PEND);
    end

    // Output data, last accepted bus value and the overrun pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out  <= {NUM_DISP{4'hF}};
            dash_out <= '1;
            last_acc <= BUS_DASH;
            overrun  <= 1'b0;
        end else begin
            overrun <= (state == PEND) && !out_ready && qual && hit_q;
            if (capture) begin
                bcd_out  <= dec_bcd;
                dash_out <= dec_dash;
                last_acc <= samp_q;
            end
        end
    end

`ifdef SEG7_DEC_DROP_ERR_EN
    assign err_out = '0;
`else
    logic [NUM_DISP-1:0] err_q;

    // Per-digit error flags travel with the captured data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (capture) begin
            err_q <= dec_err;
        end
    end

    assign err_out = err_q;
`endif

endmodule

// File: tb/tb_seg7_bcd_decoder.sv
// tb/tb_seg7_bcd_decoder.sv - self-checking bench for seg7_bcd_decoder
module tb_seg7_bcd_decoder;
    localparam int ND = 2;
    localparam int SC = 4;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [13:0]   seg_in;
    logic [7:0]    bcd_out;
    logic [1:0]    dash_out;
    logic [1:0]    err_out;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0]  pats [10];
    logic [13:0] hist [0:SC];
    logic [13:0] m_last;
    logic        m_pend;
    logic        m_ovr;
    logic [7:0]  m_bcd;
    logic [1:0]  m_dash;
    logic [1:0]  m_err;

    always #5 clk = ~clk;

    seg7_bcd_decoder #(.NUM_DISP(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .bcd_out   (bcd_out),
        .dash_out  (dash_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    function automatic logic [5:0] ref_digit(input logic [6:0] p);
        for (int v = 0; v < 10; v++) begin
            if (pats[v] == p) return {2'b00, 4'(v)};
        end
        if (p == DASH) return {2'b01, 4'hF};
        return {2'b10, 4'hE};
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= SC; k++) hist[k] = {DASH, DASH};
        m_last = {DASH, DASH};
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        m_bcd  = 8'hFF;
        m_dash = 2'b11;
        m_err  = 2'b00;
    endtask

    // Reference: a bus value qualifies once the last SC samples agree and differ from the last accepted one.
    task automatic model_step();
        logic       stable;
        logic       fresh;
        logic       qual;
        logic       cap;
        logic [5:0] d0;
        logic [5:0] d1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        stable = 1'b1;
        for (int k = 1; k < SC; k++) if (hist[k] !== hist[0]) stable = 1'b0;
        fresh = stable && (hist[SC] !== hist[0]);
        d0 = ref_digit(hist[0][6:0]);
        d1 = ref_digit(hist[0][13:7]);
        qual = stable && (hist[0] !== m_last);
`ifdef SEG7_DEC_DROP_ERR_EN
        qual = qual && !(d0[5] | d1[5]);
`endif
        cap   = qual && (!m_pend || out_ready);
        m_ovr = m_pend && !out_ready && qual && fresh;
        if (cap) begin
            m_bcd  = {d1[3:0], d0[3:0]};
            m_dash = {d1[4], d0[4]};
`ifdef SEG7_DEC_DROP_ERR_EN
            m_err  = 2'b00;
`else
            m_err  = {d1[5], d0[5]};
`endif
            m_last = hist[0];
            m_pend = 1'b1;
        end else if (m_pend && out_ready) begin
            m_pend = 1'b0;
        end
        for (int k = SC; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = seg_in;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        seg_in = {DASH, DASH};
        out_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({out_valid, overrun, bcd_out, dash_out, err_out} !== {1'b0, 1'b0, 8'hFF, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_values got v=%b o=%b bcd=%h dash=%b err=%b", out_valid, overrun, bcd_out, dash_out, err_out);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0 || bcd_out !== 8'hFF || dash_out !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_dash_silent got valid_cycles=%0d bcd=%h dash=%b want 0 ff 11", seen, bcd_out, dash_out);
        end
    endtask

    task automatic test_glitch();
        int seen;
        out_ready = 1'b1;
        seg_in = {DASH, pats[8]};
        seen = 0;
        for (int i = 0; i < SC - 1; i++) begin
            tick();
            if (out_valid) seen++;
        end
        seg_in = {DASH, DASH};
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL glitch_filter got valid_cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_stable_digit();
        out_ready = 1'b1;
        seg_in = {pats[3], pats[2]};
        for (int k = 1; k <= SC + 3; k++) begin
            tick();
            n_tests++;
            if (out_valid !== (k == SC + 1)) begin
                n_fail++;
                $display("FAIL stable_latency edge=%0d got valid=%b want %b", k, out_valid, (k == SC + 1));
            end
            if (k == SC + 1) begin
                n_tests++;
                if (bcd_out !== 8'h32 || dash_out !== 2'b00 || err_out !== 2'b00) begin
                    n_fail++;
                    $display("FAIL stable_data got bcd=%h dash=%b err=%b want 32 00 00", bcd_out, dash_out, err_out);
                end
            end
        end
    endtask

    task automatic test_repeat_after_glitch();
        int seen;
        out_ready = 1'b1;
        seen = 0;
        seg_in = {pats[8], pats[8]};
        for (int i = 0; i < SC - 1; i++) begin
            tick();
            if (out_valid) seen++;
        end
        seg_in = {pats[3], pats[2]};
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL repeat_silent got valid_cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_backpressure();
        int  bound;
        int  pulses;
        int  held_bad;
        out_ready = 1'b0;
        seg_in = {pats[5], pats[5]};
        bound = 0;
        while (!out_valid && bound < 20) begin
            tick();
            bound++;
        end
        n_tests++;
        if (!out_valid || bcd_out !== 8'h55) begin
            n_fail++;
            $display("FAIL bp_first got valid=%b bcd=%h want 1 55", out_valid, bcd_out);
        end
        seg_in = {pats[7], pats[7]};
        pulses = 0;
        held_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (overrun) pulses++;
            if (!out_valid || bcd_out !== 8'h55) held_bad++;
        end
        n_tests++;
        if (pulses != 1 || held_bad != 0) begin
            n_fail++;
            $display("FAIL bp_overrun got pulses=%0d held_errors=%0d want 1 0", pulses, held_bad);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (!out_valid || bcd_out !== 8'h77 || overrun) begin
            n_fail++;
            $display("FAIL bp_handoff got valid=%b bcd=%h ovr=%b want 1 77 0", out_valid, bcd_out, overrun);
        end
        tick();
        n_tests++;
        if (out_valid || bcd_out !== 8'h77) begin
            n_fail++;
            $display("FAIL bp_drain got valid=%b bcd=%h want 0 77", out_valid, bcd_out);
        end
    endtask

    task automatic test_invalid();
        int bound;
        out_ready = 1'b0;
        seg_in = {pats[1], BAD};
        bound = 0;
        while (!out_valid && bound < 12) begin
            tick();
            bound++;
        end
`ifdef SEG7_DEC_DROP_ERR_EN
        n_tests++;
        if (out_valid || err_out !== 2'b00) begin
            n_fail++;
            $display("FAIL invalid_dropped got valid=%b err=%b want 0 00", out_valid, err_out);
        end
`else
        n_tests++;
        if (!out_valid || bcd_out !== 8'h1E || err_out !== 2'b01 || dash_out !== 2'b00) begin
            n_fail++;
            $display("FAIL invalid_emit got valid=%b bcd=%h err=%b dash=%b want 1 1e 01 00", out_valid, bcd_out, err_out, dash_out);
        end
`endif
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int hold;
        int r0;
        int r1;
        logic [6:0] p0;
        logic [6:0] p1;
        int cyc;
        cyc = 0;
        while (cyc < 600) begin
            r0 = $urandom_range(0, 11);
            r1 = $urandom_range(0, 11);
            p0 = (r0 < 10) ? pats[r0] : ((r0 == 10) ? DASH : BAD);
            p1 = (r1 < 10) ? pats[r1] : ((r1 == 10) ? DASH : BAD);
            seg_in = {p1, p0};
            hold = $urandom_range(1, 7);
            for (int i = 0; i < hold; i++) begin
                out_ready = ($urandom_range(0, 2) != 0);
                tick();
                cyc++;
                n_tests++;
                if ({out_valid, overrun, bcd_out, dash_out, err_out} !== {m_pend, m_ovr, m_bcd, m_dash, m_err}) begin
                    n_fail++;
                    $display("FAIL random_model cyc=%0d got v=%b o=%b bcd=%h dash=%b err=%b want v=%b o=%b bcd=%h dash=%b err=%b",
                             cyc, out_valid, overrun, bcd_out, dash_out, err_out, m_pend, m_ovr, m_bcd, m_dash, m_err);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int bound;
        rst_n = 1'b0;
        seg_in = {DASH, DASH};
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        seg_in = {pats[9], pats[4]};
        bound = 0;
        while (!out_valid && bound < 20) begin
            tick();
            bound++;
        end
        n_tests++;
        if (!out_valid || bcd_out !== 8'h94) begin
            n_fail++;
            $display("FAIL areset_pend got valid=%b bcd=%h want 1 94", out_valid, bcd_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, overrun, bcd_out, dash_out, err_out} !== {1'b0, 1'b0, 8'hFF, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL areset_immediate got v=%b o=%b bcd=%h dash=%b err=%b", out_valid, overrun, bcd_out, dash_out, err_out);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        seg_in = {DASH, DASH};
        for (int i = 0; i < 6; i++) tick();
        n_tests++;
        if (out_valid || bcd_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL areset_after got valid=%b bcd=%h want 0 ff", out_valid, bcd_out);
        end
    endtask

    initial begin
        pats[0] = 7'b0000001; pats[1] = 7'b1001111; pats[2] = 7'b0010010; pats[3] = 7'b0000110;
        pats[4] = 7'b1001100; pats[5] = 7'b0100100; pats[6] = 7'b0100000; pats[7] = 7'b0001111;
        pats[8] = 7'b0000000; pats[9] = 7'b0000100;
        rst_n = 1'b0;
        out_ready = 1'b0;
        seg_in = {DASH, DASH};
        model_reset();
        test_reset();
        test_glitch();
        test_stable_digit();
        test_repeat_after_glitch();
        test_backpressure();
        test_invalid();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_bcd_decoder.md
# seg7_bcd_decoder

Decodes a bus of NUM_DISP seven-segment patterns (bit order a..g, MSB to LSB, segment active-low) back into BCD digits for loop-back checking and for reading displays driven by other counter blocks. It filters out transient patterns, decodes only bus values that stay stable, and presents each new decoded value once on a valid/ready output port. It sits on the sink side of the counter display path. Its reset and dash conventions match the display encoder.

## Interface
- NUM_DISP, 1, number of 7-segment digits on the bus
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (legal 1..255)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- seg_in  in  NUM_DISP*7  segment patterns; digit i at bits [7i+6:7i]; assumed synchronous to clk
- bcd_out  out  NUM_DISP*4  decoded digits; digit i at bits [4i+3:4i]
- dash_out  out  NUM_DISP  per-digit flag, pattern was dash 7'b1111110
- err_out  out  NUM_DISP  per-digit flag, pattern was neither a decimal digit nor dash
- out_valid  out  1  decoded value pending
- out_ready  in  1  consumer accepts the value
- overrun  out  1  one-cycle pulse when a new value qualifies while the previous one is still pending

## Operation
- Decode table: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Dash 1111110 -> bcd 4'hF, dash=1.
- Any other pattern -> bcd 4'hE, err=1.
- samp_q registers seg_in every cycle.
- cnt (8 bit): set to 1 when seg_in != samp_q; otherwise increments, saturating at STABLE_CYCLES.
- Stability applies to the whole bus. A change on any digit restarts cnt.
- last_acc holds the last accepted bus value. Reset value is {NUM_DISP{7'b1111110}}, so the encoder's reset dashes produce no output.
- qual = (cnt == STABLE_CYCLES) && (samp_q != last_acc).
- FSM states: IDLE (nothing pending) and PEND (out_valid=1).
- capture = qual && (IDLE || out_ready).
- On capture:
  - bcd_out, dash_out and err_out load decode(samp_q).
  - last_acc loads samp_q.
  - State goes to or stays in PEND.
- PEND && out_ready && !qual -> IDLE; outputs hold their values.
- PEND && !out_ready: outputs stay frozen. When cnt reaches STABLE_CYCLES from a lower value with samp_q != last_acc, overrun is registered high for one cycle. The pending value is kept. The newer pattern is captured on the handshake edge if it is still qualifying.
- A pattern equal to last_acc never produces a new output. Example sequence: 3 -> glitch -> 3 is silent.

## Timing
- Reset values:
  - bcd_out = all 4'hF
  - dash_out = all 1
  - err_out = 0
  - out_valid = 0
  - overrun = 0
  - State = IDLE
  - samp_q = dash pattern
  - cnt = STABLE_CYCLES
- Latency: seg_in changes to P and is first sampled at edge E0. out_valid rises after edge E0+STABLE_CYCLES.
- A pulse shorter than STABLE_CYCLES cycles is ignored.
- out_valid and data stay stable until the edge where out_valid && out_ready.
- Handshake and qual on the same edge: new data loads, out_valid stays 1, no overrun, no bubble.
- rst_n asserted mid-operation: all state returns to reset values immediately. The pending value is lost.

## Configuration
- SEG7_DEC_DROP_ERR_EN defined:
  - A qualifying bus value containing any invalid digit is not captured: no out_valid, no overrun.
  - last_acc is unchanged.
  - err_out is tied 0.
  - Valid digits and dashes behave as specified above.
- SEG7_DEC_DROP_ERR_EN undefined: invalid digits are emitted with bcd 4'hE and err=1, as specified above.

## Test plan
- Reset test, NUM_DISP=2, STABLE_CYCLES=4:
  - Stimulus: hold seg_in=dash,dash.
  - Required: bcd_out=8'hFF, dash_out=2'b11, out_valid stays 0.
- Stable digit:
  - Stimulus: seg_in={0000110,0010010}, out_ready=1.
  - Required: out_valid rises 4 edges after first sample, for one cycle; bcd_out=8'h32.
- Glitch filter:
  - Stimulus: 3-cycle pulse of digit 8, then back to dash.
  - Required: no out_valid. Repeating the accepted value after a glitch also produces no out_valid.
- Backpressure:
  - Stimulus: out_ready=0; present 5, then 7, each stable.
  - Required: bcd=5 held; one overrun pulse when 7 qualifies. Raising out_ready gives a handshake on 5, then 7 on the next cycle with no gap.
- Invalid pattern 1111111:
  - Required with macro undefined: bcd digit E, err=1.
  - Required with SEG7_DEC_DROP_ERR_EN defined: no out_valid.
- Async reset while PEND:
  - Required: out_valid drops immediately; outputs return to reset values without a clock edge.
